// File: rtl/uart_tx_periph_6502_pkg.sv
// Shared definitions for the 6502 transmit-only serial console: register map,
// STATUS bit positions, transmitter states and the FIFO-count saturation helper.
package uart_tx_periph_6502_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IRQ   = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // A 256-deep FIFO holds 256 entries, which does not fit the 8-bit DATA read.
  function automatic logic [7:0] sat8(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_periph_6502_if.sv
// CPU-side bus of the serial console: phase-2 level, address, write data,
// read/write strobe, and the read-data path back to the chip data mux.
interface uart_tx_periph_6502_if;
  logic        clk2out;
  logic [15:0] ab;
  logic [7:0]  cpu_do;
  logic        rw;
  logic [7:0]  rd_data;
  logic        rd_sel;

  modport master (output clk2out, ab, cpu_do, rw, input rd_data, rd_sel);
  modport slave  (input clk2out, ab, cpu_do, rw, output rd_data, rd_sel);
endinterface

// File: rtl/sync_fifo_6502.sv
// Single-clock first-word-fall-through FIFO; power-of-two depth so the
// pointers wrap naturally. A push while full is accepted only alongside a pop.
module sync_fifo_6502 #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_periph_6502.sv
// Memory-mapped 8N1 transmit console for the 6502 bus: register decode,
// byte FIFO, programmable bit timer, transmit FSM and level interrupt.
//
//   state    | meaning
//   TX_IDLE  | line high; pops the next byte as soon as the FIFO is non-empty
//   TX_START | start bit (low) for DIV+1 cycles
//   TX_DATA  | eight data bits LSB first, DIV+1 cycles each
//   TX_STOP  | stop bit (high) for DIV+1 cycles
module uart_tx_periph_6502
  import uart_tx_periph_6502_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'h8000,
  parameter int          DEPTH   = 16,
  parameter logic [7:0]  DIV_RST = 8'd9
) (
  input  logic                 eclk,
  input  logic                 ereset,
  uart_tx_periph_6502_if.slave bus,
  output logic                 txd,
  output logic                 irq_n
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk2out_q;
  logic          hit;
  logic          wstb;
  logic          push;
  logic          pop;
  logic          ien;
  logic          ovf;
  logic          irq;
  logic          busy;
  logic [7:0]    div;
  logic [7:0]    status;
  logic [7:0]    rd_mux;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_data;

  tx_state_t     state, state_n;
  logic [7:0]    bitcnt, bitcnt_n;
  logic [2:0]    bitidx, bitidx_n;
  logic [7:0]    shreg, shreg_n;

  // A write is taken on the falling edge of phase 2, once per bus cycle.
  assign hit  = (bus.ab[15:2] == BASE[15:2]);
  assign wstb = clk2out_q & ~bus.clk2out & hit & ~bus.rw;
  assign push = wstb & (bus.ab[1:0] == REG_DATA);

  sync_fifo_6502 #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (eclk),
    .rst     (ereset),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.cpu_do),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy = (state != TX_IDLE);
  assign irq  = ien & fifo_empty & ~busy;

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      clk2out_q <= 1'b0;
      ien       <= 1'b0;
      div       <= DIV_RST;
      ovf       <= 1'b0;
      irq_n     <= 1'b1;
    end else begin
      clk2out_q <= bus.clk2out;
      irq_n     <= ~irq;
      if (wstb && bus.ab[1:0] == REG_CTRL) ien <= bus.cpu_do[0];
      if (wstb && bus.ab[1:0] == REG_DIV)  div <= bus.cpu_do;
      if (wstb && bus.ab[1:0] == REG_STATUS)
        ovf <= 1'b0;
      else if (push && fifo_full && !pop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state  <= TX_IDLE;
      bitcnt <= 8'd0;
      bitidx <= 3'd0;
      shreg  <= 8'd0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      bitidx <= bitidx_n;
      shreg  <= shreg_n;
    end
  end

  // The bit timer reloads from DIV at every bit start, so a DIV write lands on the next bit.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    bitidx_n = bitidx;
    shreg_n  = shreg;
    pop      = 1'b0;
    txd      = 1'b1;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_n  = fifo_data;
          bitcnt_n = div;
          state_n  = TX_START;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (bitcnt == 8'd0) begin
          bitcnt_n = div;
          bitidx_n = 3'd0;
          state_n  = TX_DATA;
        end else begin
          bitcnt_n = bitcnt - 8'd1;
        end
      end
      TX_DATA: begin
        txd = shreg[bitidx];
        if (bitcnt == 8'd0) begin
          bitcnt_n = div;
          if (bitidx == 3'd7) state_n = TX_STOP;
          else                bitidx_n = bitidx + 3'd1;
        end else begin
          bitcnt_n = bitcnt - 8'd1;
        end
      end
      TX_STOP: begin
        if (bitcnt == 8'd0) state_n = TX_IDLE;
        else                bitcnt_n = bitcnt - 8'd1;
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    status           = 8'h00;
    status[ST_IRQ]   = irq;
    status[ST_OVF]   = ovf;
    status[ST_BUSY]  = busy;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
  end

  always_comb begin
    rd_mux = 8'h00;
    if (hit) begin
      case (bus.ab[1:0])
        REG_DATA:   rd_mux = sat8(9'(fifo_count));
        REG_STATUS: rd_mux = status;
        REG_CTRL:   rd_mux = {7'b0, ien};
        REG_DIV:    rd_mux = div;
        default:    rd_mux = 8'h00;
      endcase
    end
  end

  assign bus.rd_data = rd_mux;
  assign bus.rd_sel  = hit & bus.rw;

endmodule

// File: tb/tb_uart_tx_periph_6502.sv
// Self-checking bench for uart_tx_periph_6502: CPU bus writes/reads, a txd/irq_n
// sample log, and expected frames built from the byte, DIV and write timing.
module tb_uart_tx_periph_6502;
  localparam logic [15:0] BASE = 16'h8000;
  localparam logic [1:0] O_DATA = 2'd0, O_STATUS = 2'd1, O_CTRL = 2'd2, O_DIV = 2'd3;

  logic eclk = 1'b0;
  logic ereset;
  logic txd;
  logic irq_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic txd_log [65536];
  logic irq_log [65536];

  uart_tx_periph_6502_if bus();

  uart_tx_periph_6502 #(.BASE(BASE), .DEPTH(16), .DIV_RST(8'd9)) dut (
    .eclk   (eclk),
    .ereset (ereset),
    .bus    (bus),
    .txd    (txd),
    .irq_n  (irq_n)
  );

  always #5 eclk = ~eclk;

  // cyc = number of rising edges so far; log index n is the state after edge n.
  always @(posedge eclk) cyc <= cyc + 1;
  always @(negedge eclk) begin
    if (cyc < 65536) begin
      txd_log[cyc] = txd;
      irq_log[cyc] = irq_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d, output int w);
    @(negedge eclk);
    bus.ab = BASE | {14'd0, off}; bus.cpu_do = d; bus.rw = 1'b0; bus.clk2out = 1'b1;
    @(negedge eclk);
    bus.clk2out = 1'b0;
    @(negedge eclk);
    w = cyc; bus.rw = 1'b1; bus.ab = 16'h0000;
    #1;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [7:0] d);
    @(negedge eclk);
    bus.ab = BASE | {14'd0, off}; bus.rw = 1'b1;
    #1;
    d = bus.rd_data;
  endtask

  task automatic wait_until(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 40000) begin
      @(negedge eclk); #1; g++;
    end
  endtask

  task automatic find_start(input int from, output int s);
    s = -1;
    for (int i = from; i < from + 20000 && i < 65536; i++) begin
      wait_until(i);
      if (txd_log[i] === 1'b0) begin s = i; break; end
    end
  endtask

  // Expected line: start 0, data LSB first, stop 1; a slot beginning after the
  // DIV write edge wc uses db+1 cycles, otherwise da+1.
  task automatic check_frame(input int start, input logic [7:0] b, input int da, input int db,
                             input int wc, output int fend);
    int t;
    t = start;
    for (int s = 0; s < 10; s++) begin
      logic v;
      int   len;
      int   bad;
      v   = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      len = (t > wc) ? db + 1 : da + 1;
      bad = 0;
      wait_until(t + len - 1);
      for (int k = 0; k < len; k++) if (txd_log[t+k] !== v) bad++;
      check($sformatf("frame_%02h_slot%0d_badcycles", b, s), bad, 0);
      t += len;
    end
    wait_until(t);
    check("frame_idle_after_stop", txd_log[t], 1'b1);
    fend = t;
  endtask

  function automatic logic [7:0] status_exp(input bit irq, input bit ovf, input bit busy, input int cnt);
    return {irq, 3'b000, ovf, busy, (cnt == 16), (cnt == 0)};
  endfunction

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    int w, w2, wd, s, fend, busy_bad, model_cnt, zeros, n, div, exp_s;
    bit model_ovf;
    logic [7:0] q[$];

    bus.clk2out = 1'b0; bus.ab = 16'h0000; bus.cpu_do = 8'h00; bus.rw = 1'b1;
    ereset = 1'b1;
    repeat (3) @(negedge eclk);
    #1;
    // Reset state
    check("reset_txd", txd, 1'b1);
    check("reset_irq_n", irq_n, 1'b1);
    @(negedge eclk); ereset = 1'b0; #1;
    bus_read(O_STATUS, d); check("reset_status", d, 8'h01);
    check("rd_sel_on_hit_read", bus.rd_sel, 1'b1);
    bus_read(O_DIV, d);    check("reset_div", d, 8'h09);
    bus_read(O_CTRL, d);   check("reset_ctrl", d, 8'h00);
    bus_read(O_DATA, d);   check("reset_count", d, 8'h00);
    @(negedge eclk); bus.ab = BASE + 16'd4; #1;
    check("miss_rd_data", bus.rd_data, 8'h00);
    check("miss_rd_sel", bus.rd_sel, 1'b0);

    // Single 0xA5 frame at DIV=9
    bus_write(O_DATA, 8'hA5, w);
    busy_bad = 0;
    for (int i = 1; i <= 100; i++) begin
      bus_read(O_STATUS, d);
      if (d[2] !== 1'b1) busy_bad++;
    end
    check("busy_during_frame_bad", busy_bad, 0);
    bus_read(O_STATUS, d); check("status_after_frame", d, status_exp(0, 0, 0, 0));
    find_start(w, s); check("pop_to_start_latency", s, w + 1);
    if (s < 0) s = w + 1;
    check_frame(s, 8'hA5, 9, 9, -1, fend);

    // Overflow with the line stalled at DIV=255
    model_cnt = 0; model_ovf = 0;
    bus_write(O_DIV, 8'd255, w);
    b = 8'($urandom) & 8'hFE;
    bus_write(O_DATA, b, w);
    find_start(w, s); check("stall_frame_start", s, w + 1);
    if (s < 0) s = w + 1;
    for (int i = 1; i < 17; i++) begin
      bus_write(O_DATA, 8'($urandom), w2);
      model_cnt++;
    end
    bus_read(O_DATA, d);   check("full_count", d, 8'(model_cnt));
    bus_read(O_STATUS, d); check("full_no_ovf", d, status_exp(0, model_ovf, 1, model_cnt));
    bus_write(O_DATA, 8'($urandom), w2);
    if (model_cnt == 16) model_ovf = 1; else model_cnt++;
    bus_read(O_STATUS, d); check("ovf_set", d, status_exp(0, model_ovf, 1, model_cnt));
    bus_read(O_DATA, d);   check("count_after_drop", d, 8'(model_cnt));
    bus_write(O_STATUS, 8'($urandom), w2);
    model_ovf = 0;
    bus_read(O_STATUS, d); check("ovf_cleared", d, status_exp(0, model_ovf, 1, model_cnt));

    // Reset in the middle of data bit 0 (bit 0 forced low above)
    wait_until(s + 256 + 100);
    check("pre_reset_txd_low", txd, 1'b0);
    #1 ereset = 1'b1;
    #1;
    check("reset_mid_frame_txd", txd, 1'b1);
    check("reset_mid_frame_irq_n", irq_n, 1'b1);
    @(negedge eclk); @(negedge eclk); ereset = 1'b0; #1;
    w = cyc;
    bus_read(O_STATUS, d); check("post_reset_status", d, 8'h01);
    bus_read(O_DIV, d);    check("post_reset_div", d, 8'h09);
    bus_read(O_DATA, d);   check("post_reset_count", d, 8'h00);
    wait_until(w + 300);
    zeros = 0;
    for (int i = w; i <= w + 300; i++) if (txd_log[i] !== 1'b1) zeros++;
    check("no_resend_after_reset", zeros, 0);

    // Interrupt timing
    bus_write(O_CTRL, 8'h01, w);
    wait_until(w + 1);
    check("irq_n_at_ctrl_write", irq_log[w], 1'b1);
    check("irq_n_one_after", irq_log[w+1], 1'b0);
    bus_read(O_STATUS, d); check("status_irq", d, status_exp(1, 0, 0, 0));
    b = 8'($urandom);
    bus_write(O_DATA, b, w2);
    wait_until(w2 + 1);
    check("irq_n_at_push", irq_log[w2], 1'b0);
    check("irq_n_after_push", irq_log[w2+1], 1'b1);
    find_start(w2, s); check("irq_frame_start", s, w2 + 1);
    if (s < 0) s = w2 + 1;
    check_frame(s, b, 9, 9, -1, fend);
    wait_until(fend + 1);
    check("irq_n_at_idle", irq_log[fend], 1'b1);
    check("irq_n_after_idle", irq_log[fend+1], 1'b0);
    bus_write(O_CTRL, 8'h00, w);

    // DIV 9 -> 3 in the middle of data bit 2
    b = 8'($urandom);
    bus_write(O_DATA, b, w);
    find_start(w, s); check("divchg_frame_start", s, w + 1);
    if (s < 0) s = w + 1;
    wait_until(s + 33);
    bus_write(O_DIV, 8'd3, wd);
    check_frame(s, b, 9, 3, wd, fend);

    // Random back-to-back bursts; round 0 covers DIV=0
    for (int r = 0; r < 3; r++) begin
      div = (r == 0) ? 0 : int'($urandom_range(1, 3));
      n   = (r == 0) ? 3 : int'($urandom_range(3, 6));
      q.delete();
      bus_write(O_DIV, 8'(div), wd);
      w2 = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(O_DATA, b, w);
        if (i == 0) w2 = w;
      end
      fend = w2;
      for (int i = 0; i < n; i++) begin
        exp_s = (i == 0) ? w2 + 1 : fend + 1;
        find_start(fend, s);
        check($sformatf("burst%0d_frame%0d_start", r, i), s, exp_s);
        if (s < 0) s = exp_s;
        check_frame(s, q[i], div, div, -1, fend);
      end
      bus_read(O_STATUS, d); check($sformatf("burst%0d_status", r), d, status_exp(0, 0, 0, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
